// File: rtl/banked_mem_oob_pkg.sv
// rtl/banked_mem_oob_pkg.sv - shared types, constants and bank geometry helper for banked_mem_oob
package banked_mem_oob_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  localparam int OOB_CNT_W = 16;
  localparam logic [OOB_CNT_W-1:0] OOB_CNT_MAX = '1;

  // Bank 0 is the deep bank; every other bank shares one shallow depth.
  function automatic int bank_depth(input int sel, input int bank0_depth, input int bankn_depth);
    return (sel == 0) ? bank0_depth : bankn_depth;
  endfunction

endpackage

// File: rtl/banked_mem_oob_decode.sv
// rtl/banked_mem_oob_decode.sv - {bank_sel, index} to {clamped bank, index, in_range}
module banked_mem_oob_decode
  import banked_mem_oob_pkg::*;
#(
  parameter int NBANKS      = 6,
  parameter int BANK0_DEPTH = 48,
  parameter int BANK_DEPTH  = 24,
  parameter int IDX_W       = 6,
  parameter int BANK_SEL_W  = 3
) (
  input  logic [BANK_SEL_W+IDX_W-1:0] i_addr,
  output logic [BANK_SEL_W-1:0]       o_sel,
  output logic [IDX_W-1:0]            o_idx,
  output logic                        o_in_range
);

  localparam logic [BANK_SEL_W-1:0] LAST_SEL = BANK_SEL_W'(NBANKS - 1);

  logic [BANK_SEL_W-1:0] w_bank_sel;

  assign w_bank_sel = i_addr[BANK_SEL_W+IDX_W-1:IDX_W];
  // Unused select codes fold onto the last bank rather than faulting.
  assign o_sel      = (w_bank_sel >= LAST_SEL) ? LAST_SEL : w_bank_sel;
  assign o_idx      = i_addr[IDX_W-1:0];
  assign o_in_range = int'(o_idx) < bank_depth(int'(o_sel), BANK0_DEPTH, BANK_DEPTH);

endmodule

// File: rtl/banked_mem_oob.sv
// rtl/banked_mem_oob.sv - banked register-file store with OOB detection and clear sequencer; optional BANKED_MEM_OOB_STATS_EN
module banked_mem_oob
  import banked_mem_oob_pkg::*;
#(
  parameter int WIDTH       = 64,
  parameter int NBANKS      = 6,
  parameter int BANK0_DEPTH = 48,
  parameter int BANK_DEPTH  = 24,
  parameter int IDX_W       = 6,
  parameter int BANK_SEL_W  = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_clear_req,
  output logic                        o_busy,
  input  logic                        i_wr_en,
  input  logic [BANK_SEL_W+IDX_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]            i_wr_data,
  output logic                        o_wr_oob,
  input  logic                        i_rd_en,
  input  logic [BANK_SEL_W+IDX_W-1:0] i_rd_addr,
  output logic                        o_rd_valid,
  output logic [WIDTH-1:0]            o_rd_data,
  output logic                        o_rd_oob,
  output logic [OOB_CNT_W-1:0]        o_oob_cnt
);

  localparam int B0_AW = (BANK0_DEPTH > 1) ? $clog2(BANK0_DEPTH) : 1;
  localparam int BN_AW = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
  localparam logic [IDX_W-1:0] CLR_LAST = IDX_W'(BANK0_DEPTH - 1);

  state_e                r_state;
  state_e                w_next_state;
  logic                  w_busy;
  logic [IDX_W-1:0]      r_clr_idx;

  logic [WIDTH-1:0]      r_bank0 [BANK0_DEPTH];
  logic [WIDTH-1:0]      r_bankn [NBANKS-1][BANK_DEPTH];

  logic [BANK_SEL_W-1:0] w_wr_sel;
  logic [IDX_W-1:0]      w_wr_idx;
  logic                  w_wr_in_range;
  logic [BANK_SEL_W-1:0] w_rd_sel;
  logic [IDX_W-1:0]      w_rd_idx;
  logic                  w_rd_in_range;
  logic                  w_wr_ok;
  logic                  w_wr_drop_oob;
  logic [WIDTH-1:0]      w_rd_word;

  banked_mem_oob_decode #(
    .NBANKS(NBANKS), .BANK0_DEPTH(BANK0_DEPTH), .BANK_DEPTH(BANK_DEPTH),
    .IDX_W(IDX_W), .BANK_SEL_W(BANK_SEL_W)
  ) u_wr_decode (
    .i_addr(i_wr_addr), .o_sel(w_wr_sel), .o_idx(w_wr_idx), .o_in_range(w_wr_in_range)
  );

  banked_mem_oob_decode #(
    .NBANKS(NBANKS), .BANK0_DEPTH(BANK0_DEPTH), .BANK_DEPTH(BANK_DEPTH),
    .IDX_W(IDX_W), .BANK_SEL_W(BANK_SEL_W)
  ) u_rd_decode (
    .i_addr(i_rd_addr), .o_sel(w_rd_sel), .o_idx(w_rd_idx), .o_in_range(w_rd_in_range)
  );

  // Writes are only honoured while idle; busy-time writes vanish without a flag.
  assign w_wr_ok       = i_wr_en && !w_busy && w_wr_in_range;
  assign w_wr_drop_oob = i_wr_en && !w_busy && !w_wr_in_range;
  assign o_busy        = w_busy;

  // Next-state logic: clear walks the deep bank's index range once, then idles.
  always_comb begin
    w_next_state = r_state;
    w_busy       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (i_clear_req) w_next_state = ST_CLEAR;
      end
      ST_CLEAR: begin
        w_busy = 1'b1;
        if (r_clr_idx == CLR_LAST) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State and clear index; reset always (re)starts a full clear from entry 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_CLEAR;
      r_clr_idx <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_busy && (r_clr_idx != CLR_LAST)) r_clr_idx <= r_clr_idx + IDX_W'(1);
      else                                   r_clr_idx <= '0;
    end
  end

  // Storage update: clear zeroes one row across all banks deep enough to hold it.
  always_ff @(posedge clk) begin
    if (!reset && w_busy) begin
      r_bank0[r_clr_idx[B0_AW-1:0]] <= '0;
      if (int'(r_clr_idx) < BANK_DEPTH) begin
        for (int b = 0; b < NBANKS - 1; b++) r_bankn[b][r_clr_idx[BN_AW-1:0]] <= '0;
      end
    end else if (!reset && w_wr_ok) begin
      if (w_wr_sel == '0) begin
        r_bank0[w_wr_idx[B0_AW-1:0]] <= i_wr_data;
      end else begin
        for (int b = 1; b < NBANKS; b++) begin
          if (w_wr_sel == BANK_SEL_W'(b)) r_bankn[b-1][w_wr_idx[BN_AW-1:0]] <= i_wr_data;
        end
      end
    end
  end

  // Read mux; out-of-range reads yield zero instead of touching storage.
  always_comb begin
    w_rd_word = '0;
    if (w_rd_in_range) begin
      if (w_rd_sel == '0) begin
        w_rd_word = r_bank0[w_rd_idx[B0_AW-1:0]];
      end else begin
        for (int b = 1; b < NBANKS; b++) begin
          if (w_rd_sel == BANK_SEL_W'(b)) w_rd_word = r_bankn[b-1][w_rd_idx[BN_AW-1:0]];
        end
      end
    end
  end

  // Registered read response and write-OOB pulse; rd_data holds between reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_rd_valid <= 1'b0;
      o_rd_data  <= '0;
      o_rd_oob   <= 1'b0;
      o_wr_oob   <= 1'b0;
    end else begin
      o_rd_valid <= i_rd_en;
      o_rd_oob   <= i_rd_en && !w_rd_in_range;
      o_wr_oob   <= w_wr_drop_oob;
      if (i_rd_en) o_rd_data <= w_rd_word;
    end
  end

`ifdef BANKED_MEM_OOB_STATS_EN
  logic [OOB_CNT_W-1:0] r_oob_cnt;

  // Saturating count of dropped OOB writes; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_oob_cnt <= '0;
    end else if (w_wr_drop_oob && (r_oob_cnt != OOB_CNT_MAX)) begin
      r_oob_cnt <= r_oob_cnt + OOB_CNT_W'(1);
    end
  end

  assign o_oob_cnt = r_oob_cnt;
`else
  assign o_oob_cnt = '0;
`endif

endmodule

// File: tb/tb_banked_mem_oob.sv
// tb/tb_banked_mem_oob.sv - scoreboard bench for banked_mem_oob; honours BANKED_MEM_OOB_STATS_EN
module tb_banked_mem_oob;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_clear_req;
  logic        o_busy;
  logic        i_wr_en;
  logic [8:0]  i_wr_addr;
  logic [63:0] i_wr_data;
  logic        o_wr_oob;
  logic        i_rd_en;
  logic [8:0]  i_rd_addr;
  logic        o_rd_valid;
  logic [63:0] o_rd_data;
  logic        o_rd_oob;
  logic [15:0] o_oob_cnt;

  always #5 clk = ~clk;

  banked_mem_oob dut (
    .clk(clk), .reset(reset), .i_clear_req(i_clear_req), .o_busy(o_busy),
    .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data), .o_wr_oob(o_wr_oob),
    .i_rd_en(i_rd_en), .i_rd_addr(i_rd_addr), .o_rd_valid(o_rd_valid),
    .o_rd_data(o_rd_data), .o_rd_oob(o_rd_oob), .o_oob_cnt(o_oob_cnt)
  );

  typedef struct {
    logic [63:0] data;
    logic        oob;
  } rd_exp_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  rd_exp_t     sb_q[$];
  logic [63:0] model [6][64];
  int          clr_left = 0;
  logic        exp_busy, exp_rd_valid, exp_wr_oob;
  logic [15:0] exp_cnt = 16'h0;
  bit          mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void decode(input logic [8:0] a, output int sel, output int idx, output bit oob);
    int bs;
    bs  = int'(a[8:6]);
    sel = (bs >= 5) ? 5 : bs;
    idx = int'(a[5:0]);
    oob = idx >= ((sel == 0) ? 48 : 24);
  endfunction

  // Reference behaviour for one clock edge, using the inputs present at that edge.
  task automatic model_edge();
    int s, i;
    bit o;
    rd_exp_t e;
    if (reset) begin
      clr_left     = 48;
      exp_rd_valid = 1'b0;
      exp_wr_oob   = 1'b0;
      exp_cnt      = 16'h0;
    end else begin
      exp_rd_valid = i_rd_en;
      exp_wr_oob   = 1'b0;
      if (i_rd_en) begin
        decode(i_rd_addr, s, i, o);
        e.data = o ? 64'h0 : model[s][i];
        e.oob  = o;
        sb_q.push_back(e);
      end
      if (i_wr_en && clr_left == 0) begin
        decode(i_wr_addr, s, i, o);
        if (!o) model[s][i] = i_wr_data;
        else begin
          exp_wr_oob = 1'b1;
`ifdef BANKED_MEM_OOB_STATS_EN
          if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'h1;
`endif
        end
      end
      if (clr_left > 0) begin
        for (int b = 0; b < 6; b++) model[b][48 - clr_left] = 64'h0;
        clr_left--;
      end else if (i_clear_req) begin
        clr_left = 48;
      end
    end
    exp_busy = (clr_left > 0);
  endtask

  task automatic cyc(input bit rst, input bit clr, input bit we, input logic [8:0] wa,
                     input logic [63:0] wd, input bit re, input logic [8:0] ra);
    reset = rst; i_clear_req = clr;
    i_wr_en = we; i_wr_addr = wa; i_wr_data = wd;
    i_rd_en = re; i_rd_addr = ra;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 9'h0, 64'h0, 0, 9'h0);
  endtask

  task automatic rd(input logic [8:0] a);
    cyc(0, 0, 0, 9'h0, 64'h0, 1, a);
  endtask

  task automatic wr(input logic [8:0] a, input logic [63:0] d);
    cyc(0, 0, 1, a, d, 0, 9'h0);
  endtask

  // Monitor: compares status every cycle and pops the scoreboard on each read response.
  always @(negedge clk) begin
    rd_exp_t e;
    if (mon_en) begin
      chk("busy", o_busy, exp_busy);
      chk("wr_oob", o_wr_oob, exp_wr_oob);
      chk("rd_valid", o_rd_valid, exp_rd_valid);
      chk("oob_cnt", o_oob_cnt, exp_cnt);
      if (o_rd_valid) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rd_unexpected: got rd_valid=1 expected no pending read");
        end else begin
          e = sb_q.pop_front();
          chk("rd_data", o_rd_data, e.data);
          chk("rd_oob", o_rd_oob, e.oob);
        end
      end else begin
        chk("rd_oob_idle", o_rd_oob, 64'h0);
      end
    end
  end

  initial begin
    for (int b = 0; b < 6; b++)
      for (int k = 0; k < 64; k++) model[b][k] = 64'h0;

    cyc(1, 0, 0, 9'h0, 64'h0, 0, 9'h0);
    mon_en = 1'b1;
    idle(48);
    rd(9'h000); rd(9'h02F); rd(9'h057);

    wr(9'h02F, 64'hDEAD_BEEF_0123_4567);
    rd(9'h02F);

    wr(9'h058, 64'h1);
    rd(9'h057); rd(9'h058);

    wr(9'h1C3, 64'hA5);
    rd(9'h143);

    wr(9'h005, 64'h1);
    cyc(0, 0, 1, 9'h005, 64'h2, 1, 9'h005);
    rd(9'h005);

    cyc(0, 1, 0, 9'h0, 64'h0, 0, 9'h0);
    idle(5);
    wr(9'h02F, 64'hFFFF_0000_FFFF_0000);
    idle(4);
    cyc(1, 0, 0, 9'h0, 64'h0, 0, 9'h0);
    idle(48);
    rd(9'h02F); rd(9'h1C3); rd(9'h143); rd(9'h005); rd(9'h000);

    for (int n = 0; n < 600; n++) begin
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 59) == 0),
          $urandom_range(0, 1) == 1, 9'($urandom_range(0, 511)), {$urandom, $urandom},
          $urandom_range(0, 1) == 1, 9'($urandom_range(0, 511)));
    end

    idle(2);
    chk("sb_drain", 64'(sb_q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
